// File: rtl/obj_motion_ctrl_if.sv
// -----------------------------------------------------------------------------
// obj_motion_ctrl_if
// Purpose : groups the frame/control inputs and the object state outputs that
//           pass between the motion controller and the VGA display stage.
// Signals :
//   frame_sync   display -> ctrl  vertical sync, rising edge = frame start
//   start        display -> ctrl  level, leaves IDLE or OVER
//   hit          display -> ctrl  collision flag
//   obj_x_begin  ctrl -> display  object x (12 bit)
//   obj_y_begin  ctrl -> display  object y (12 bit)
//   end_show     ctrl -> display  1 = object hidden
//   score        ctrl -> display  hit count (4 bit)
//   game_over    ctrl -> display  1 while the game is over
// Modports: slave = controller side, master = display / stimulus side.
// -----------------------------------------------------------------------------
interface obj_motion_ctrl_if;
   logic        frame_sync;
   logic        start;
   logic        hit;
   logic [11:0] obj_x_begin;
   logic [11:0] obj_y_begin;
   logic        end_show;
   logic [3:0]  score;
   logic        game_over;

   modport slave (
      input  frame_sync,
      input  start,
      input  hit,
      output obj_x_begin,
      output obj_y_begin,
      output end_show,
      output score,
      output game_over
   );

   modport master (
      output frame_sync,
      output start,
      output hit,
      input  obj_x_begin,
      input  obj_y_begin,
      input  end_show,
      input  score,
      input  game_over
   );
endinterface

// File: rtl/obj_motion_ctrl.sv
// -----------------------------------------------------------------------------
// obj_motion_ctrl
// Purpose : frame-rate controller for a leftward-scrolling object on one of
//           four lanes. Produces the object's top-left corner, a hide flag,
//           the hit score and a game-over flag for the VGA display stage.
// Ports   :
//   clk_vga  pixel clock, the only clock
//   rst      synchronous reset, active low, sampled on rising clk_vga
//   bus      obj_motion_ctrl_if.slave (frame_sync/start/hit in,
//            obj_x_begin/obj_y_begin/end_show/score/game_over out)
// Config  : define OBJ_SPEEDUP_EN to raise the per-frame step with the score
//           (SPEED + score[3:2], capped at 2*SPEED). Undefined: step = SPEED.
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module obj_motion_ctrl #(
   parameter logic [11:0] START_X     = 12'd600,
   parameter logic [11:0] SPEED       = 12'd4,
   parameter logic [11:0] LANE_Y0     = 12'd80,
   parameter logic [11:0] LANE_STEP   = 12'd96,
   parameter logic [5:0]  HIDE_FRAMES = 6'd30,
   parameter logic [3:0]  SCORE_MAX   = 4'd15
) (
   input  logic              clk_vga,
   input  logic              rst,
   obj_motion_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HIT  = 2'd2,
      ST_OVER = 2'd3
   } state_t;

   // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3), shifting towards the MSB.
   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      logic fb;
      fb = v[7] ^ v[5] ^ v[4] ^ v[3];
      return {v[6:0], fb};
   endfunction

   // Score increment that saturates at 15.
   function automatic logic [3:0] score_inc(input logic [3:0] s);
      logic [3:0] r;
      if (s == 4'd15) begin
         r = s;
      end else begin
         r = s + 4'd1;
      end
      return r;
   endfunction

   state_t      state_q, state_d;
   logic [11:0] x_q, x_d;
   logic [11:0] y_q, y_d;
   logic        end_show_q, end_show_d;
   logic [3:0]  score_q, score_d;
   logic        game_over_q, game_over_d;
   logic [5:0]  hide_q, hide_d;
   logic        hit_lat_q, hit_lat_d;
   logic [7:0]  lfsr_q, lfsr_d;
   logic        sync_q, sync_qq;

   logic        frame_tick_s;
   logic [11:0] spawn_y_s;
   logic [3:0]  score_inc_s;
   logic [11:0] step_s;

   assign frame_tick_s = sync_q & ~sync_qq;
   assign spawn_y_s    = LANE_Y0 + (LANE_STEP * {10'd0, lfsr_q[1:0]});
   assign score_inc_s  = score_inc(score_q);

`ifdef OBJ_SPEEDUP_EN
   logic [11:0] step_q, step_d;

   // Step for a given score: SPEED + score[3:2], never more than 2*SPEED.
   function automatic logic [11:0] step_for_score(input logic [3:0] s);
      logic [11:0] raw;
      logic [11:0] cap;
      raw = SPEED + {10'd0, s[3:2]};
      cap = {SPEED[10:0], 1'b0};
      if (raw > cap) begin
         raw = cap;
      end else begin
         raw = raw;
      end
      return raw;
   endfunction

   assign step_s = step_q;

   // Effective step follows the score; a new game restarts at SPEED.
   always_comb begin
      step_d = step_q;
      if ((state_q == ST_RUN) && frame_tick_s && hit_lat_q) begin
         step_d = step_for_score(score_inc_s);
      end else if ((state_q == ST_OVER) && bus.start) begin
         step_d = SPEED;
      end else begin
         step_d = step_q;
      end
   end

   // Step register.
   always_ff @(posedge clk_vga) begin
      if (!rst) begin
         step_q <= SPEED;
      end else begin
         step_q <= step_d;
      end
   end
`else
   assign step_s = SPEED;
`endif

   // Hit latch: a hit seen during RUN is held until the next frame tick,
   // which consumes it (the FSM reads the latched value on that tick).
   always_comb begin
      hit_lat_d = hit_lat_q;
      if (frame_tick_s) begin
         hit_lat_d = 1'b0;
      end else if ((state_q == ST_RUN) && bus.hit) begin
         hit_lat_d = 1'b1;
      end else begin
         hit_lat_d = hit_lat_q;
      end
   end

   // Next-state and next-output logic of the game FSM.
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      end_show_d  = end_show_q;
      score_d     = score_q;
      game_over_d = game_over_q;
      hide_d      = hide_q;
      lfsr_d      = lfsr_next(lfsr_q);
      case (state_q)
         ST_IDLE: begin
            end_show_d = 1'b1;
            // Spawn has priority over any frame tick in the same cycle.
            if (bus.start) begin
               x_d        = START_X;
               y_d        = spawn_y_s;
               end_show_d = 1'b0;
               state_d    = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (frame_tick_s) begin
               if (hit_lat_q) begin
                  // Hit beats a simultaneous miss.
                  score_d    = score_inc_s;
                  hide_d     = HIDE_FRAMES;
                  end_show_d = 1'b1;
                  if (score_inc_s == SCORE_MAX) begin
                     game_over_d = 1'b1;
                     state_d     = ST_OVER;
                  end else begin
                     state_d = ST_HIT;
                  end
               end else if (x_q < step_s) begin
                  // Miss: respawn rather than underflow past x=0.
                  x_d = START_X;
                  y_d = spawn_y_s;
               end else begin
                  x_d = x_q - step_s;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_HIT: begin
            end_show_d = 1'b1;
            if (frame_tick_s) begin
               // A count of 1 reaches 0 on this tick; 0 is treated the same
               // so the state can never get stuck.
               if (hide_q <= 6'd1) begin
                  hide_d     = 6'd0;
                  x_d        = START_X;
                  y_d        = spawn_y_s;
                  end_show_d = 1'b0;
                  state_d    = ST_RUN;
               end else begin
                  hide_d = hide_q - 6'd1;
               end
            end else begin
               state_d = ST_HIT;
            end
         end
         ST_OVER: begin
            end_show_d  = 1'b1;
            game_over_d = 1'b1;
            if (bus.start) begin
               score_d     = 4'd0;
               x_d         = START_X;
               y_d         = spawn_y_s;
               end_show_d  = 1'b0;
               game_over_d = 1'b0;
               state_d     = ST_RUN;
            end else begin
               state_d = ST_OVER;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk_vga) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         x_q         <= START_X;
         y_q         <= LANE_Y0;
         end_show_q  <= 1'b1;
         score_q     <= 4'd0;
         game_over_q <= 1'b0;
         hide_q      <= 6'd0;
         hit_lat_q   <= 1'b0;
         lfsr_q      <= 8'hA5;
         sync_q      <= 1'b0;
         sync_qq     <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         end_show_q  <= end_show_d;
         score_q     <= score_d;
         game_over_q <= game_over_d;
         hide_q      <= hide_d;
         hit_lat_q   <= hit_lat_d;
         lfsr_q      <= lfsr_d;
         sync_q      <= bus.frame_sync;
         sync_qq     <= sync_q;
      end
   end

   assign bus.obj_x_begin = x_q;
   assign bus.obj_y_begin = y_q;
   assign bus.end_show    = end_show_q;
   assign bus.score       = score_q;
   assign bus.game_over   = game_over_q;

endmodule

// File: tb/tb_obj_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_obj_motion_ctrl
// Directed bench for obj_motion_ctrl: reset state, idle freeze, scrolling,
// hit scoring and hide period, miss respawn at x=0, saturation to game over,
// restart, and reset in the middle of the hide period.
// -----------------------------------------------------------------------------
module tb_obj_motion_ctrl;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

`ifdef OBJ_SPEEDUP_EN
   localparam int STEP_AT8 = 6;
`else
   localparam int STEP_AT8 = 4;
`endif

   obj_motion_ctrl_if bus ();

   obj_motion_ctrl dut (
      .clk_vga (clk),
      .rst     (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One frame: rising edge of frame_sync, tick acts two edges later.
   task automatic frame();
      @(posedge clk); #1 bus.frame_sync = 1'b1;
      repeat (3) @(posedge clk);
      #1 bus.frame_sync = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame();
   endtask

   task automatic hit_pulse();
      @(posedge clk); #1 bus.hit = 1'b1;
      @(posedge clk); #1 bus.hit = 1'b0;
   endtask

   task automatic start_pulse();
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
   endtask

   function automatic logic lane_ok(input logic [11:0] y);
      return (y == 12'd80) || (y == 12'd176) || (y == 12'd272) || (y == 12'd368);
   endfunction

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b0;
      bus.frame_sync = 1'b0;
      bus.start = 1'b0;
      bus.hit = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_x", bus.obj_x_begin, 600);
      chk("rst_y", bus.obj_y_begin, 80);
      chk("rst_end_show", bus.end_show, 1);
      chk("rst_score", bus.score, 0);
      chk("rst_game_over", bus.game_over, 0);
      chk("rst_lfsr", dut.lfsr_q, 8'hA5);
      rst = 1'b1;

      // Idle: frame ticks do not move the object
      frames(2);
      chk("idle_x", bus.obj_x_begin, 600);
      chk("idle_end_show", bus.end_show, 1);

      // Start, then 10 frames of scrolling
      start_pulse();
      chk("start_x", bus.obj_x_begin, 600);
      chk("start_end_show", bus.end_show, 0);
      chk("start_lane", lane_ok(bus.obj_y_begin), 1);
      frames(10);
      chk("run10_x", bus.obj_x_begin, 560);
      chk("run10_end_show", bus.end_show, 0);
      chk("run10_lane", lane_ok(bus.obj_y_begin), 1);

      // Hit mid-frame is scored on the next tick
      hit_pulse();
      chk("hit_before_tick_score", bus.score, 0);
      frame();
      chk("hit_score", bus.score, 1);
      chk("hit_end_show", bus.end_show, 1);
      chk("hit_x_frozen", bus.obj_x_begin, 560);
      chk("hit_hide_cnt", dut.hide_q, 30);
      frames(10);
      hit_pulse();  // ignored while hidden
      frames(19);
      chk("hide29_x", bus.obj_x_begin, 560);
      chk("hide29_end_show", bus.end_show, 1);
      frame();
      chk("respawn_x", bus.obj_x_begin, 600);
      chk("respawn_end_show", bus.end_show, 0);
      chk("respawn_score", bus.score, 1);
      chk("respawn_lane", lane_ok(bus.obj_y_begin), 1);

      // Miss: 150 ticks to x=0, 151st respawns
      frames(150);
      chk("miss_x0", bus.obj_x_begin, 0);
      frame();
      chk("miss_respawn_x", bus.obj_x_begin, 600);
      chk("miss_score", bus.score, 1);
      chk("miss_end_show", bus.end_show, 0);

      // Score up to 14, checking the step once the score reaches 8
      for (int s = 2; s <= 14; s++) begin
         hit_pulse();
         frame();
         frames(30);
         if (s == 8) begin
            frame();
            chk("step_at_score8", bus.obj_x_begin, 600 - STEP_AT8);
         end
      end
      chk("score14", bus.score, 14);
      chk("score14_end_show", bus.end_show, 0);

      // 15th hit ends the game
      hit_pulse();
      frame();
      chk("over_score", bus.score, 15);
      chk("over_flag", bus.game_over, 1);
      chk("over_end_show", bus.end_show, 1);
      frames(2);
      chk("over_frozen_x", bus.obj_x_begin, 600);
      chk("over_frozen_flag", bus.game_over, 1);

      // Restart from OVER
      start_pulse();
      chk("restart_score", bus.score, 0);
      chk("restart_flag", bus.game_over, 0);
      chk("restart_end_show", bus.end_show, 0);
      chk("restart_x", bus.obj_x_begin, 600);
      frame();
      chk("restart_step", bus.obj_x_begin, 596);

      // Reset during the hide period with counter at 12
      hit_pulse();
      frame();
      frames(18);
      chk("hide_cnt12", dut.hide_q, 12);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_x", bus.obj_x_begin, 600);
      chk("mid_rst_y", bus.obj_y_begin, 80);
      chk("mid_rst_score", bus.score, 0);
      chk("mid_rst_end_show", bus.end_show, 1);
      chk("mid_rst_hide", dut.hide_q, 0);
      chk("mid_rst_lfsr", dut.lfsr_q, 8'hA5);
      rst = 1'b1;
      frames(2);
      chk("post_rst_idle_x", bus.obj_x_begin, 600);
      chk("post_rst_idle_end_show", bus.end_show, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
